// File: rtl/sdram_pro_read_pkg.sv
// SDRAM command encodings, address field positions and burst-length helper
// shared by the read engine and its neighbours on the arbiter mux.
package sdram_pro_read_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] NO_OPERATION    = 4'b0111;
  localparam logic [3:0] ACTIVE          = 4'b0011;
  localparam logic [3:0] READ            = 4'b0101;
  localparam logic [3:0] WRITE           = 4'b0100;
  localparam logic [3:0] BURST_TERMINATE = 4'b0110;
  localparam logic [3:0] PRECHARGE       = 4'b0010;
  localparam logic [3:0] AUTO_REFRESH    = 4'b0001;
  localparam logic [3:0] LOAD_MODE       = 4'b0000;

  localparam int BANK_MSB = 22;
  localparam int BANK_LSB = 21;
  localparam int ROW_MSB  = 20;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;

  // Zero-length requests read one word; oversize requests stop at the page end.
  function automatic logic [9:0] clamp_burst(input logic [9:0] len, input logic [9:0] max_len);
    if (len == 10'd0)
      return 10'd1;
    else if (len > max_len)
      return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sdram_pro_read_if.sv
// Read-engine bus: arbiter grant and request fields, SDRAM command/DQ side
// and the read-FIFO write port.
interface sdram_pro_read_if;
  logic        init_end;
  logic        rd_en;
  logic [22:0] rd_addr;
  logic [9:0]  rd_burst_len;
  logic [15:0] rd_sdram_data;
  logic [3:0]  rd_sdram_cmd;
  logic [11:0] rd_sdram_addr;
  logic [1:0]  rd_sdram_bank;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        rd_end;

  modport master (
    output init_end, rd_en, rd_addr, rd_burst_len, rd_sdram_data,
    input  rd_sdram_cmd, rd_sdram_addr, rd_sdram_bank, rd_data, rd_ack, rd_end
  );

  modport slave (
    input  init_end, rd_en, rd_addr, rd_burst_len, rd_sdram_data,
    output rd_sdram_cmd, rd_sdram_addr, rd_sdram_bank, rd_data, rd_ack, rd_end
  );
endinterface

// File: rtl/sdram_pro_rd_dly.sv
// Valid/data delay line aligning READ-slot valids with DQ: rd_ack DEPTH cycles after issue.
// No backpressure: every word that arrives is written to the FIFO.
module sdram_pro_rd_dly #(
  parameter int DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        issue,
  input  logic [15:0] sdram_data,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic        busy
);

  logic [DEPTH-2:0] vld_pipe;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe <= '0;
      rd_ack   <= 1'b0;
      rd_data  <= 16'd0;
    end else begin
      vld_pipe <= {vld_pipe[DEPTH-3:0], issue};
      rd_ack   <= vld_pipe[DEPTH-2];
      if (vld_pipe[DEPTH-2])
        rd_data <= sdram_data;
    end
  end

  assign busy = |vld_pipe;

endmodule

// File: rtl/sdram_pro_read.sv
// Full-page read engine: ACTIVE, READ, BURST_TERMINATE after L words, PRECHARGE.
// First rd_ack CAS_LATENCY+1 after READ; no backpressure, the read FIFO takes every rd_ack.
module sdram_pro_read
  import sdram_pro_read_pkg::*;
#(
  parameter int CAS_LATENCY = 3,
  parameter int CNT_TRCD    = 2,
  parameter int CNT_TRP     = 2,
  parameter int MAX_BURST   = 512
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  sdram_pro_read_if.slave rd_if
);

  typedef enum logic [3:0] {
    RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ_BEGIN, RD_READ_DATA,
    RD_TERMINATE, RD_PRECHARGE, RD_TRP, RD_END
  } rd_state_t;

  localparam logic [7:0] TRCD_LAST = 8'(CNT_TRCD - 1);
  localparam logic [7:0] TRP_LAST  = 8'(CNT_TRP - 1);
  localparam logic [9:0] MAX_LEN   = 10'(MAX_BURST);

  rd_state_t   state;
  logic [3:0]  cmd;
  logic [11:0] addr;
  logic [1:0]  bank;
  logic        rd_end;
  logic [7:0]  cnt_wait;
  logic [9:0]  cnt_burst;
  logic [1:0]  lat_bank;
  logic [11:0] lat_row;
  logic [8:0]  lat_col;
  logic [9:0]  lat_len;
  logic        issue;
  logic        pipe_busy;

  // Each cycle the bus carries READ or one of its follow-on NOPs, a word is due CL later.
  assign issue = (state == RD_READ_BEGIN) || (state == RD_READ_DATA);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= RD_IDLE;
      cmd       <= NO_OPERATION;
      addr      <= 12'hfff;
      bank      <= 2'b11;
      rd_end    <= 1'b0;
      cnt_wait  <= 8'd0;
      cnt_burst <= 10'd0;
      lat_bank  <= 2'd0;
      lat_row   <= 12'd0;
      lat_col   <= 9'd0;
      lat_len   <= 10'd0;
    end else begin
      cmd    <= NO_OPERATION;
      addr   <= 12'hfff;
      bank   <= 2'b11;
      rd_end <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (rd_if.init_end && rd_if.rd_en) begin
            lat_bank <= rd_if.rd_addr[BANK_MSB:BANK_LSB];
            lat_row  <= rd_if.rd_addr[ROW_MSB:ROW_LSB];
            lat_col  <= rd_if.rd_addr[COL_MSB:COL_LSB];
            lat_len  <= clamp_burst(rd_if.rd_burst_len, MAX_LEN);
            state    <= RD_ACTIVE;
            cmd      <= ACTIVE;
            addr     <= rd_if.rd_addr[ROW_MSB:ROW_LSB];
            bank     <= rd_if.rd_addr[BANK_MSB:BANK_LSB];
          end
        end
        RD_ACTIVE: begin
          cnt_wait <= 8'd0;
          state    <= RD_TRCD;
        end
        RD_TRCD: begin
          if (cnt_wait == TRCD_LAST) begin
            cnt_wait <= 8'd0;
            state    <= RD_READ_BEGIN;
            cmd      <= READ;
            addr     <= {3'b000, lat_col};
            bank     <= lat_bank;
          end else begin
            cnt_wait <= cnt_wait + 8'd1;
          end
        end
        RD_READ_BEGIN: begin
          if (lat_len == 10'd1) begin
            cnt_burst <= 10'd0;
            state     <= RD_TERMINATE;
            cmd       <= BURST_TERMINATE;
          end else begin
            cnt_burst <= 10'd1;
            state     <= RD_READ_DATA;
          end
        end
        RD_READ_DATA: begin
          // BST lands on the bus exactly L cycles after READ.
          if (cnt_burst == lat_len - 10'd1) begin
            cnt_burst <= 10'd0;
            state     <= RD_TERMINATE;
            cmd       <= BURST_TERMINATE;
          end else begin
            cnt_burst <= cnt_burst + 10'd1;
          end
        end
        RD_TERMINATE: begin
          state <= RD_PRECHARGE;
          cmd   <= PRECHARGE;
          addr  <= 12'h000;
          bank  <= lat_bank;
        end
        RD_PRECHARGE: begin
          cnt_wait <= 8'd0;
          state    <= RD_TRP;
        end
        RD_TRP: begin
          if (cnt_wait == TRP_LAST) begin
            cnt_wait <= 8'd0;
            state    <= RD_END;
            rd_end   <= ~pipe_busy;
          end else begin
            cnt_wait <= cnt_wait + 8'd1;
          end
        end
        RD_END: begin
          if (rd_end)
            state <= RD_IDLE;
          else if (!pipe_busy)
            rd_end <= 1'b1;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  sdram_pro_rd_dly #(
    .DEPTH(CAS_LATENCY + 1)
  ) u_rd_dly (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .issue     (issue),
    .sdram_data(rd_if.rd_sdram_data),
    .rd_data   (rd_if.rd_data),
    .rd_ack    (rd_if.rd_ack),
    .busy      (pipe_busy)
  );

  assign rd_if.rd_sdram_cmd  = cmd;
  assign rd_if.rd_sdram_addr = addr;
  assign rd_if.rd_sdram_bank = bank;
  assign rd_if.rd_end        = rd_end;

endmodule

// File: tb/tb_sdram_pro_read.sv
// Bench for sdram_pro_read: SDRAM model returning column indices, expected
// words queued per request and popped on each rd_ack.
module tb_sdram_pro_read;
  import sdram_pro_read_pkg::*;

  localparam int CL   = 3;
  localparam int TRCD = 2;
  localparam int TRP  = 2;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  sdram_pro_read_if bus();

  sdram_pro_read #(
    .CAS_LATENCY(CL),
    .CNT_TRCD   (TRCD),
    .CNT_TRP    (TRP),
    .MAX_BURST  (512)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rd_if    (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  int act_cyc, rd_cyc, bst_cyc, pre_cyc, end_cyc;
  int n_act = 0, n_rd = 0, n_end = 0, ack_idx = 0, model_stop = 0;
  logic [11:0] act_row, rd_a;
  logic [1:0]  act_bank, rd_bank, pre_bank;
  logic        pre_a10;
  logic        model_on = 1'b0;
  logic [8:0]  model_col = 9'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe the bus at the falling edge, score rd_ack, drive DQ.
  task automatic step();
    @(negedge sys_clk);
    cyc++;
    case (bus.rd_sdram_cmd)
      ACTIVE: begin
        act_cyc  = cyc;
        act_row  = bus.rd_sdram_addr;
        act_bank = bus.rd_sdram_bank;
        n_act++;
      end
      READ: begin
        rd_cyc     = cyc;
        rd_a       = bus.rd_sdram_addr;
        rd_bank    = bus.rd_sdram_bank;
        ack_idx    = 0;
        n_rd++;
        model_on   = 1'b1;
        model_col  = bus.rd_sdram_addr[8:0];
        model_stop = cyc + 100000;
      end
      BURST_TERMINATE: begin
        bst_cyc    = cyc;
        model_stop = cyc + CL;
      end
      PRECHARGE: begin
        pre_cyc  = cyc;
        pre_a10  = bus.rd_sdram_addr[10];
        pre_bank = bus.rd_sdram_bank;
      end
      default: ;
    endcase
    if (bus.rd_end) begin
      end_cyc = cyc;
      n_end++;
    end
    if (bus.rd_ack) begin
      check_eq("ack_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_eq("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        check_eq("ack_cycle", cyc - rd_cyc, CL + 1 + ack_idx);
      end
      ack_idx++;
    end
    if (model_on && cyc >= rd_cyc + CL && cyc < model_stop)
      bus.rd_sdram_data = 16'((int'(model_col) + (cyc - rd_cyc - CL)) % 512);
    else
      bus.rd_sdram_data = 16'hdead;
  endtask

  task automatic run_rd(input logic [22:0] addr, input logic [9:0] len, input int exp_len);
    int n_end0, n_act0, t;
    for (int k = 0; k < exp_len; k++)
      exp_q.push_back(16'((int'(addr[8:0]) + k) % 512));
    act_cyc = -1; rd_cyc = -1; bst_cyc = -1; pre_cyc = -1; end_cyc = -1;
    n_end0 = n_end;
    n_act0 = n_act;
    bus.rd_addr      = addr;
    bus.rd_burst_len = len;
    bus.rd_en        = 1'b1;
    t = 0;
    while (n_act == n_act0 && t < 50) begin
      step();
      t++;
    end
    check_eq("active_seen", n_act - n_act0, 1);
    // Request fields and grant change after latching; they must be ignored.
    bus.rd_en        = 1'b0;
    bus.rd_addr      = ~addr;
    bus.rd_burst_len = 10'd2;
    t = 0;
    while (n_end == n_end0 && t < 1000) begin
      step();
      t++;
    end
    repeat (4) step();
    check_eq("act_bank", 32'(act_bank), 32'(addr[22:21]));
    check_eq("act_row", 32'(act_row), 32'(addr[20:9]));
    check_eq("trcd_gap", rd_cyc - act_cyc, TRCD + 1);
    check_eq("read_addr", 32'(rd_a), 32'({3'b000, addr[8:0]}));
    check_eq("read_bank", 32'(rd_bank), 32'(addr[22:21]));
    check_eq("bst_cycle", bst_cyc - rd_cyc, exp_len);
    check_eq("pre_cycle", pre_cyc - rd_cyc, exp_len + 1);
    check_eq("pre_a10", 32'(pre_a10), 32'd0);
    check_eq("pre_bank", 32'(pre_bank), 32'(addr[22:21]));
    check_eq("end_cycle", end_cyc - rd_cyc, exp_len + 2 + TRP);
    check_eq("end_count", n_end - n_end0, 1);
    check_eq("word_count", ack_idx, exp_len);
    check_eq("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    model_on = 1'b0;
  endtask

  initial begin
    int bad, t, n_rd0;
    bus.init_end      = 1'b0;
    bus.rd_en         = 1'b0;
    bus.rd_addr       = 23'd0;
    bus.rd_burst_len  = 10'd0;
    bus.rd_sdram_data = 16'd0;
    sys_rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_cmd", 32'(bus.rd_sdram_cmd), 32'(NO_OPERATION));
    check_eq("rst_addr", 32'(bus.rd_sdram_addr), 32'h fff);
    check_eq("rst_bank", 32'(bus.rd_sdram_bank), 32'd3);
    check_eq("rst_data", 32'(bus.rd_data), 32'd0);
    check_eq("rst_ack", 32'(bus.rd_ack), 32'd0);
    check_eq("rst_end", 32'(bus.rd_end), 32'd0);
    sys_rst_n = 1'b1;

    // Grant without init_end must not start anything.
    bus.rd_en = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (bus.rd_sdram_cmd !== NO_OPERATION || bus.rd_ack !== 1'b0 || bus.rd_end !== 1'b0)
        bad++;
    end
    check_eq("no_init_idle", bad, 0);
    bus.rd_en    = 1'b0;
    bus.init_end = 1'b1;
    step();

    run_rd({2'd1, 12'h00a, 9'd0}, 10'd4, 4);
    run_rd({2'd2, 12'h123, 9'd0}, 10'd512, 512);
    run_rd({2'd3, 12'h7ff, 9'd100}, 10'd0, 1);
    run_rd({2'd0, 12'h001, 9'd0}, 10'd700, 512);
    run_rd({2'd1, 12'h0ff, 9'd510}, 10'd4, 4);

    // Reset two cycles after READ: immediate reset values, no data delivered.
    n_rd0 = n_rd;
    bus.rd_addr      = {2'd2, 12'h055, 9'd20};
    bus.rd_burst_len = 10'd8;
    bus.rd_en        = 1'b1;
    t = 0;
    while (n_rd == n_rd0 && t < 50) begin
      step();
      t++;
    end
    check_eq("pre_reset_read", n_rd - n_rd0, 1);
    repeat (2) step();
    sys_rst_n = 1'b0;
    model_on  = 1'b0;
    #1;
    check_eq("mid_rst_cmd", 32'(bus.rd_sdram_cmd), 32'(NO_OPERATION));
    check_eq("mid_rst_addr", 32'(bus.rd_sdram_addr), 32'hfff);
    check_eq("mid_rst_bank", 32'(bus.rd_sdram_bank), 32'd3);
    check_eq("mid_rst_end", 32'(bus.rd_end), 32'd0);
    bad = 0;
    repeat (6) begin
      step();
      if (bus.rd_ack !== 1'b0 || bus.rd_data !== 16'd0 || bus.rd_sdram_cmd !== NO_OPERATION)
        bad++;
    end
    check_eq("mid_rst_quiet", bad, 0);
    sys_rst_n = 1'b1;
    run_rd({2'd2, 12'h055, 9'd20}, 10'd8, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_pro_read.md
Name: sdram_pro_read

Overview:
Full-page-burst read engine for the SDRAM controller. It is the read-side counterpart of the page-burst writer. On an arbiter grant it opens a row, issues READ, and truncates the burst after rd_burst_len words (1..512, within one row) with BURST_TERMINATE. It then precharges the bank and streams the returned words, CAS-aligned, into the read FIFO with a write strobe. Its command, address and bank outputs feed the arbiter mux alongside the init, refresh and write engines.

Parameters:
CAS_LATENCY, 3, cycles from READ on the command bus to the first valid word on rd_sdram_data (2 or 3 only).
CNT_TRCD, 2, idle cycles between ACTIVE and READ.
CNT_TRP, 2, idle cycles after PRECHARGE.
MAX_BURST, 512, page length in words; larger requests are clamped to this value.

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  SDRAM initialisation complete; no activity before it is high
rd_en  in  1  arbiter grant (level)
rd_addr  in  23  {bank[22:21], row[20:9], col[8:0]}
rd_burst_len  in  10  words to read
rd_sdram_data  in  16  DQ bus sampled from the SDRAM
rd_sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n}, registered
rd_sdram_addr  out  12  A[11:0], registered
rd_sdram_bank  out  2  BA, registered
rd_data  out  16  captured read word, valid when rd_ack is high
rd_ack  out  1  read-FIFO write enable, one pulse per word
rd_end  out  1  one-cycle pulse: the read transaction is complete and the bus is free

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low (sys_rst_n).
- Reset values: cmd = NO_OPERATION, addr = 12'hfff, bank = 2'b11, rd_data = 0, rd_ack = 0, rd_end = 0, state = RD_IDLE, all counters 0.
- Reset mid-burst aborts immediately to the reset values. No PRECHARGE is issued; the arbiter re-runs precharge-all after reset.
- rd_addr and rd_burst_len are latched on the RD_IDLE→RD_ACTIVE transition and ignored afterwards.
- Burst length: 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST. The latched length is referred to as L below.
- Column wrap: if col + L > 512, the burst wraps to column 0 of the same row (device behaviour). No error is flagged.
- State machine (three-process: state register, next-state logic, registered outputs):
  RD_IDLE: leaves when init_end && rd_en; otherwise stays. Outputs NOP.
  RD_ACTIVE: emits ACTIVE with A = row and BA = bank. Always moves to RD_TRCD.
  RD_TRCD: NOP for CNT_TRCD cycles, then RD_READ_BEGIN.
  RD_READ_BEGIN: emits READ with A = {3'b0, col}, A10 = 0 (no auto-precharge), BA = bank. Moves to RD_READ_DATA.
  RD_READ_DATA: NOP while cnt_burst counts. Moves to RD_TERMINATE so that BURST_TERMINATE reaches the bus exactly L cycles after READ.
  RD_TERMINATE: emits BURST_TERMINATE. Moves to RD_PRECHARGE.
  RD_PRECHARGE: emits PRECHARGE with A10 = 0 and BA = bank.
  RD_TRP: NOP for CNT_TRP cycles.
  RD_END: waits until the last data word has been delivered, pulses rd_end for one cycle, then returns to RD_IDLE.
- Data timing: let R be the bus cycle carrying READ.
  - Word k (k = 0..L-1) is on rd_sdram_data at R+CAS_LATENCY+k.
  - It is registered into rd_data with rd_ack high at R+CAS_LATENCY+k+1.
  - rd_ack is high for exactly L consecutive cycles and is never high outside that window.
- Valid tracking: a CAS_LATENCY+1-deep valid delay line tracks the returning data. The command side never waits on it, except that RD_END waits for the pipe to drain.
- Defaults (CL = 3, TRP = 2):
  - PRECHARGE on the bus at R+L+1.
  - Last rd_ack at R+L+3.
  - rd_end at R+L+4.
- rd_en dropping after RD_IDLE has no effect; the transaction always completes. A new transaction can start no earlier than the cycle after rd_end.

Decomposition:
- Shared defines file: command encodings NO_OPERATION, ACTIVE, READ, WRITE, BURST_TERMINATE, PRECHARGE, AUTO_REFRESH, LOAD_MODE, plus address field bit positions. This file already exists and this block reuses it unchanged.
- State encodings stay local to the module.
- One sub-module: sdram_pro_rd_dly. It is a parameterised valid/data delay line (depth CAS_LATENCY+1) that produces rd_ack and rd_data.

Test Plan:
1. init_end = 0, rd_en = 1 for 20 cycles → cmd stays NOP, rd_ack = 0, rd_end = 0.
2. rd_addr = {2'd1, 12'h00A, 9'd0}, L = 4, SDRAM model returning col index:
   - ACTIVE BA = 1, A = 0x00A; READ 3 cycles later.
   - rd_data = 0, 1, 2, 3 at R+4..R+7; BST at R+4; PRECHARGE at R+5; rd_end at R+8 only.
3. L = 512, col = 0 → 512 rd_ack pulses with contiguous data 0..511; BST at R+512; rd_end exactly once.
4. L = 0 and L = 700:
   - L = 0 gives exactly 1 word.
   - L = 700 gives exactly 512 words.
5. col = 510, L = 4 → rd_data = 510, 511, 0, 1 (row wrap).
6. sys_rst_n asserted at R+2 → all outputs at reset values immediately; after release with rd_en high, a fresh read completes normally.
